// File: rtl/vga_dither_ordered.sv
// Ordered 4x4 Bayer dither (optional per-frame temporal offset) reducing 24-bit RGB to R/G/B_BITS.
// Latency: 2 clk, one pixel per clock, de/hs/vs delayed alongside the pixel.
// Backpressure: none; free-running video stream, every input cycle yields an output cycle.
module vga_dither_ordered #(
    parameter int R_BITS   = 5,
    parameter int G_BITS   = 6,
    parameter int B_BITS   = 5,
    parameter bit SYNC_ACT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        r_i,
    input  logic [7:0]        g_i,
    input  logic [7:0]        b_i,
    input  logic              de_i,
    input  logic              hs_i,
    input  logic              vs_i,
    input  logic [1:0]        mode_i,
    output logic [R_BITS-1:0] r_o,
    output logic [G_BITS-1:0] g_o,
    output logic [B_BITS-1:0] b_o,
    output logic              de_o,
    output logic              hs_o,
    output logic              vs_o
);

    localparam int RD = 8 - R_BITS;
    localparam int GD = 8 - G_BITS;
    localparam int BD = 8 - B_BITS;

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Scale the 4-bit matrix entry to span one output LSB of the channel.
    function automatic logic [7:0] thresh(input logic [3:0] b, input int d);
        if (d <= 4)
            thresh = 8'(b) >> (4 - d);
        else
            thresh = 8'(b) << (d - 4);
    endfunction

    function automatic logic [7:0] quant(input logic [8:0] s, input int d);
        if (s[8])
            quant = 8'hFF;
        else
            quant = s[7:0] >> d;
    endfunction

    logic [1:0] x_cnt, y_cnt, frame_cnt, mode_q;
    logic       de_prev, vs_prev;
    logic       vs_act, vs_edge, de_fall;

    assign vs_act  = (vs_i == SYNC_ACT);
    assign vs_edge = vs_act && (vs_prev != SYNC_ACT);
    assign de_fall = de_prev && !de_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt     <= 2'd0;
            y_cnt     <= 2'd0;
            frame_cnt <= 2'd0;
            mode_q    <= 2'd0;
            de_prev   <= 1'b0;
            vs_prev   <= ~SYNC_ACT;
        end else begin
            x_cnt <= de_i ? x_cnt + 2'd1 : 2'd0;
            // Vsync clear takes priority over the end-of-line increment.
            if (vs_act)
                y_cnt <= 2'd0;
            else if (de_fall)
                y_cnt <= y_cnt + 2'd1;
            if (vs_edge) begin
                frame_cnt <= frame_cnt + 2'd1;
                mode_q    <= mode_i;
            end
            de_prev <= de_i;
            vs_prev <= vs_i;
        end
    end

    logic [1:0] row, col;
    logic       dither_en;
    logic [3:0] bval;
    logic [7:0] t_r, t_g, t_b;

    always_comb begin
        row       = y_cnt;
        col       = x_cnt;
        dither_en = 1'b0;
        case (mode_q)
            2'd1: dither_en = 1'b1;
            2'd2: begin
                row       = y_cnt + frame_cnt;
                col       = x_cnt + frame_cnt;
                dither_en = 1'b1;
            end
            default: dither_en = 1'b0;
        endcase
        bval = BAYER[{row, col}];
        t_r  = dither_en ? thresh(bval, RD) : 8'd0;
        t_g  = dither_en ? thresh(bval, GD) : 8'd0;
        t_b  = dither_en ? thresh(bval, BD) : 8'd0;
    end

    logic [8:0] s_r, s_g, s_b;
    logic       de_1, hs_1, vs_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_r  <= 9'd0;
            s_g  <= 9'd0;
            s_b  <= 9'd0;
            de_1 <= 1'b0;
            hs_1 <= ~SYNC_ACT;
            vs_1 <= ~SYNC_ACT;
            r_o  <= '0;
            g_o  <= '0;
            b_o  <= '0;
            de_o <= 1'b0;
            hs_o <= ~SYNC_ACT;
            vs_o <= ~SYNC_ACT;
        end else begin
            s_r  <= {1'b0, r_i} + {1'b0, t_r};
            s_g  <= {1'b0, g_i} + {1'b0, t_g};
            s_b  <= {1'b0, b_i} + {1'b0, t_b};
            de_1 <= de_i;
            hs_1 <= hs_i;
            vs_1 <= vs_i;
            r_o  <= R_BITS'(quant(s_r, RD));
            g_o  <= G_BITS'(quant(s_g, GD));
            b_o  <= B_BITS'(quant(s_b, BD));
            de_o <= de_1;
            hs_o <= hs_1;
            vs_o <= vs_1;
        end
    end

endmodule

// File: tb/tb_vga_dither_ordered.sv
// Bench for vga_dither_ordered: reference model feeds a 2-deep expectation queue,
// plus directed scenarios with hand-computed outputs.
module tb_vga_dither_ordered;

    localparam int RB = 5;
    localparam int GB = 6;
    localparam int BB = 5;
    localparam bit SA = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    r_i = 8'd0, g_i = 8'd0, b_i = 8'd0;
    logic          de_i = 1'b0, hs_i = ~SA, vs_i = ~SA;
    logic [1:0]    mode_i = 2'd0;
    logic [RB-1:0] r_o;
    logic [GB-1:0] g_o;
    logic [BB-1:0] b_o;
    logic          de_o, hs_o, vs_o;

    int total = 0;
    int bad   = 0;

    vga_dither_ordered #(.R_BITS(RB), .G_BITS(GB), .B_BITS(BB), .SYNC_ACT(SA)) dut (
        .clk(clk), .rst(rst),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .mode_i(mode_i),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
    } exp_t;

    exp_t sb[$];
    int bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int mx, my, mf, mmode;
    bit mde_p, mvs_p;

    function automatic int exp_ch(int v, int n, int bv, bit en);
        int d, t, s;
        d = 8 - n;
        t = 0;
        if (en) t = (d <= 4) ? bv / (1 << (4 - d)) : bv * (1 << (d - 4));
        s = v + t;
        return (s > 255) ? (1 << n) - 1 : s / (1 << d);
    endfunction

    // Reference model: one expectation per sampled input cycle.
    always @(posedge clk) begin
        exp_t e;
        int   row, col, bv;
        bit   en;
        if (rst) begin
            sb.delete();
            e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
            e.de = 1'b0; e.hs = ~SA; e.vs = ~SA;
            sb.push_back(e);
            sb.push_back(e);
            mx = 0; my = 0; mf = 0; mmode = 0;
            mde_p = 1'b0; mvs_p = ~SA;
        end else begin
            en  = (mmode == 1) || (mmode == 2);
            row = (mmode == 2) ? (my + mf) % 4 : my;
            col = (mmode == 2) ? (mx + mf) % 4 : mx;
            bv  = bay[row * 4 + col];
            e.r = 8'(exp_ch(int'(r_i), RB, bv, en));
            e.g = 8'(exp_ch(int'(g_i), GB, bv, en));
            e.b = 8'(exp_ch(int'(b_i), BB, bv, en));
            e.de = de_i; e.hs = hs_i; e.vs = vs_i;
            sb.push_back(e);
            if (vs_i == SA) my = 0;
            else if (mde_p && !de_i) my = (my + 1) % 4;
            mx = de_i ? (mx + 1) % 4 : 0;
            if (vs_i == SA && mvs_p != SA) begin
                mf    = (mf + 1) % 4;
                mmode = int'(mode_i);
            end
            mde_p = de_i;
            mvs_p = vs_i;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            total++;
            if (r_o !== e.r[RB-1:0] || g_o !== e.g[GB-1:0] || b_o !== e.b[BB-1:0] ||
                de_o !== e.de || hs_o !== e.hs || vs_o !== e.vs) begin
                bad++;
                $display("FAIL scoreboard t=%0t got r=%0d g=%0d b=%0d de=%b hs=%b vs=%b want r=%0d g=%0d b=%0d de=%b hs=%b vs=%b",
                         $time, r_o, g_o, b_o, de_o, hs_o, vs_o,
                         e.r[RB-1:0], e.g[GB-1:0], e.b[BB-1:0], e.de, e.hs, e.vs);
            end
        end
    end

    task automatic set_px(input logic [7:0] r, g, b, input logic de, hs, vs);
        r_i = r; g_i = g; b_i = b; de_i = de; hs_i = hs; vs_i = vs;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse();
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, SA);
        step(1);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(2);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) begin
            set_px(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, ~SA, ~SA);
            step(1);
        end
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_px(8'hA5, 8'h5A, 8'h3C, 1'b1, SA, SA);
        step(3);
        total++;
        if (r_o !== '0 || g_o !== '0 || b_o !== '0 || de_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_pixel got r=%0d g=%0d b=%0d de=%b want 0 0 0 0", r_o, g_o, b_o, de_o);
        end
        total++;
        if (hs_o !== ~SA || vs_o !== ~SA) begin
            bad++;
            $display("FAIL reset_sync got hs=%b vs=%b want %b %b", hs_o, vs_o, ~SA, ~SA);
        end
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_truncate();
        mode_i = 2'd0;
        vs_pulse();
        set_px(8'hFF, 8'h81, 8'h07, 1'b1, ~SA, ~SA);
        step(1);
        total++;
        if (de_o !== 1'b0) begin
            bad++;
            $display("FAIL latency_1clk got de_o=%b want 0", de_o);
        end
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd31 || g_o !== 6'd32 || b_o !== 5'd0 || de_o !== 1'b1) begin
            bad++;
            $display("FAIL truncate got r=%0d g=%0d b=%0d de=%b want 31 32 0 1", r_o, g_o, b_o, de_o);
        end
        step(1);
    endtask

    task automatic test_bayer();
        mode_i = 2'd1;
        vs_pulse();
        set_px(8'h04, 8'h02, 8'h00, 1'b1, ~SA, ~SA);
        step(2);
        total++;
        if (r_o !== 5'd0 || g_o !== 6'd0) begin
            bad++;
            $display("FAIL bayer_x0 got r=%0d g=%0d want 0 0", r_o, g_o);
        end
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd1 || g_o !== 6'd1) begin
            bad++;
            $display("FAIL bayer_x1 got r=%0d g=%0d want 1 1", r_o, g_o);
        end
        step(1);
    endtask

    task automatic test_saturate();
        line(3);
        line(3);
        set_px(8'hFF, 8'h00, 8'h00, 1'b1, ~SA, ~SA);
        step(1);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd31 || g_o !== 6'd0 || b_o !== 5'd0) begin
            bad++;
            $display("FAIL saturate got r=%0d g=%0d b=%0d want 31 0 0", r_o, g_o, b_o);
        end
        step(1);
    endtask

    task automatic test_temporal();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        mode_i = 2'd2;
        vs_pulse();
        set_px(8'h06, 8'h00, 8'h06, 1'b1, ~SA, ~SA);
        step(1);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd1 || g_o !== 6'd0 || b_o !== 5'd1) begin
            bad++;
            $display("FAIL temporal got r=%0d g=%0d b=%0d want 1 0 1", r_o, g_o, b_o);
        end
        step(1);
    endtask

    task automatic test_mode_latch();
        mode_i = 2'd0;
        vs_pulse();
        mode_i = 2'd1;
        set_px(8'h04, 8'h02, 8'h00, 1'b1, ~SA, ~SA);
        step(2);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd0 || g_o !== 6'd0) begin
            bad++;
            $display("FAIL mode_hold got r=%0d g=%0d want 0 0", r_o, g_o);
        end
        step(1);
        vs_pulse();
        set_px(8'h04, 8'h02, 8'h00, 1'b1, ~SA, ~SA);
        step(2);
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(1);
        total++;
        if (r_o !== 5'd1 || g_o !== 6'd1) begin
            bad++;
            $display("FAIL mode_switch got r=%0d g=%0d want 1 1", r_o, g_o);
        end
        step(1);
    endtask

    task automatic test_reset_midline();
        line(2);
        set_px(8'h40, 8'h40, 8'h40, 1'b1, ~SA, ~SA);
        step(2);
        set_px(8'hFF, 8'hFF, 8'hFF, 1'b1, SA, ~SA);
        rst = 1'b1;
        step(1);
        total++;
        if (r_o !== '0 || g_o !== '0 || b_o !== '0 || de_o !== 1'b0 || hs_o !== ~SA || vs_o !== ~SA) begin
            bad++;
            $display("FAIL midline_reset got r=%0d g=%0d b=%0d de=%b hs=%b vs=%b want 0 0 0 0 %b %b",
                     r_o, g_o, b_o, de_o, hs_o, vs_o, ~SA, ~SA);
        end
        rst = 1'b0;
        step(1);
        total++;
        if (de_o !== 1'b0 || hs_o !== ~SA) begin
            bad++;
            $display("FAIL post_reset_1clk got de=%b hs=%b want 0 %b", de_o, hs_o, ~SA);
        end
        step(1);
        total++;
        if (de_o !== 1'b1 || hs_o !== SA || r_o !== 5'd31 || g_o !== 6'd63 || b_o !== 5'd31) begin
            bad++;
            $display("FAIL post_reset_2clk got de=%b hs=%b r=%0d g=%0d b=%0d want 1 %b 31 63 31",
                     de_o, hs_o, r_o, g_o, b_o, SA);
        end
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            mode_i = 2'($urandom_range(0, 3));
            set_px(8'($urandom), 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 7) == 0) ? SA : ~SA,
                   ($urandom_range(0, 24) == 0) ? SA : ~SA);
            step(1);
        end
        rst = 1'b0;
        set_px(8'd0, 8'd0, 8'd0, 1'b0, ~SA, ~SA);
        step(3);
    endtask

    initial begin
        test_reset();
        test_truncate();
        test_bayer();
        test_saturate();
        test_temporal();
        test_mode_latch();
        test_reset_midline();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
